// File: rtl/jtframe_pll_seq_pkg.sv
// rtl/jtframe_pll_seq_pkg.sv - shared state encoding and counter sizing for the PLL sequencer
package jtframe_pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    FAIL
  } state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jtframe_pll_seq_sync.sv
// rtl/jtframe_pll_seq_sync.sv - two-flop synchronizer for the asynchronous PLL lock
module jtframe_pll_seq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/jtframe_pll_seq.sv
// rtl/jtframe_pll_seq.sv - PLL reset/lock sequencer with staggered per-domain reset release
// JTFRAME_PLLSEQ_DBG_EN adds saturating loss_cnt/try_cnt event counters.
module jtframe_pll_seq
  import jtframe_pll_seq_pkg::*;
#(
  parameter int RST_CYC    = 16,
  parameter int LOCK_TO    = 1000000,
  parameter int STABLE_CYC = 1024,
  parameter int DROP_CYC   = 4,
  parameter int GAP_CYC    = 64,
  parameter int NDOM       = 3,
  parameter int MAX_RETRY  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pll_locked,
  input  logic            restart,
  output logic            pll_rst,
  output logic [NDOM-1:0] rst_req,
  output logic            ready,
  output logic            fail
`ifdef JTFRAME_PLLSEQ_DBG_EN
  ,
  output logic [7:0]      loss_cnt,
  output logic [7:0]      try_cnt
`endif
);

  localparam int RW  = cnt_w(RST_CYC);
  localparam int TW  = cnt_w(LOCK_TO);
  localparam int SW  = cnt_w(STABLE_CYC);
  localparam int DW  = cnt_w(DROP_CYC);
  localparam int GW  = cnt_w(GAP_CYC);
  localparam int IW  = cnt_w(NDOM);
  localparam int RTW = cnt_w(MAX_RETRY);

  logic lock_s;

  jtframe_pll_seq_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  state_e          state_q, state_d;
  logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RTW-1:0]  retry_q, retry_d;
  logic            pll_rst_q, pll_rst_d;
  logic [NDOM-1:0] rst_req_q, rst_req_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            loss_evt, to_evt;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stab_d    = stab_q;
    drop_d    = drop_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    rst_req_d = rst_req_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    loss_evt  = 1'b0;
    to_evt    = 1'b0;

    if (restart) begin
      state_d   = RST_PLL;
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      stab_d    = '0;
      drop_d    = '0;
      gap_d     = '0;
      idx_d     = '0;
      retry_d   = '0;
      rst_req_d = '1;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
    end else begin
      case (state_q)
        RST_PLL: begin
          if (rst_cnt_q == RW'(RST_CYC - 1)) begin
            state_d   = WAIT_LOCK;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        WAIT_LOCK, FILTER: begin
          to_cnt_d = to_cnt_q + TW'(1);
          // The timeout is checked first so it wins over a same-cycle qualification.
          if (to_cnt_q == TW'(LOCK_TO - 1)) begin
            to_evt    = 1'b1;
            to_cnt_d  = '0;
            rst_cnt_d = '0;
            retry_d   = retry_q + RTW'(1);
            if (retry_q == RTW'(MAX_RETRY - 1)) begin
              state_d = FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = RST_PLL;
            end
          end else if (state_q == WAIT_LOCK) begin
            if (lock_s) begin
              state_d = FILTER;
              stab_d  = '0;
            end
          end else if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (stab_q == SW'(STABLE_CYC - 1)) begin
            retry_d      = '0;
            drop_d       = '0;
            gap_d        = '0;
            idx_d        = IW'(1);
            rst_req_d[0] = 1'b0;
            if (NDOM == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
        RELEASE, RUN: begin
          if (!lock_s) begin
            if (drop_q == DW'(DROP_CYC - 1)) begin
              loss_evt  = 1'b1;
              state_d   = RST_PLL;
              rst_cnt_d = '0;
              drop_d    = '0;
              rst_req_d = '1;
              ready_d   = 1'b0;
            end else begin
              drop_d = drop_q + DW'(1);
            end
          end else begin
            drop_d = '0;
          end
          if (state_q == RELEASE && !loss_evt) begin
            if (gap_q == GW'(GAP_CYC - 1)) begin
              gap_d = '0;
              idx_d = idx_q + IW'(1);
              for (int i = 0; i < NDOM; i++) begin
                if (i == int'(idx_q)) rst_req_d[i] = 1'b0;
              end
              if (idx_q == IW'(NDOM - 1)) begin
                state_d = RUN;
                ready_d = 1'b1;
              end
            end else begin
              gap_d = gap_q + GW'(1);
            end
          end
        end
        FAIL: begin
          rst_req_d = '1;
        end
        default: begin
          state_d   = RST_PLL;
          rst_cnt_d = '0;
          rst_req_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end

    pll_rst_d = (state_d == RST_PLL) || (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_PLL;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stab_q    <= '0;
      drop_q    <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      rst_req_q <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stab_q    <= stab_d;
      drop_q    <= drop_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      rst_req_q <= rst_req_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst = pll_rst_q;
  assign rst_req = rst_req_q;
  assign ready   = ready_q;
  assign fail    = fail_q;

`ifdef JTFRAME_PLLSEQ_DBG_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic [7:0] try_cnt_q, try_cnt_d;

  // Diagnostic history survives restart; only rst_n wipes it.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    try_cnt_d  = try_cnt_q;
    if (loss_evt && loss_cnt_q != 8'hff) loss_cnt_d = loss_cnt_q + 8'd1;
    if (to_evt && try_cnt_q != 8'hff) try_cnt_d = try_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
      try_cnt_q  <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
      try_cnt_q  <= try_cnt_d;
    end
  end

  assign loss_cnt = loss_cnt_q;
  assign try_cnt  = try_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = loss_evt ^ to_evt;
`endif

endmodule

// File: tb/tb_jtframe_pll_seq.sv
// tb/tb_jtframe_pll_seq.sv - directed self-checking bench for jtframe_pll_seq
module tb_jtframe_pll_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic [2:0] rst_req;
  logic       ready;
  logic       fail;
`ifdef JTFRAME_PLLSEQ_DBG_EN
  logic [7:0] loss_cnt;
  logic [7:0] try_cnt;
`endif

  int nvec  = 0;
  int nfail = 0;
  int tog_cnt = 0;
  bit tog_en  = 1'b0;
  int n;

  always #5 clk = ~clk;

  jtframe_pll_seq #(
    .RST_CYC    (4),
    .LOCK_TO    (100),
    .STABLE_CYC (8),
    .DROP_CYC   (3),
    .GAP_CYC    (5),
    .NDOM       (3),
    .MAX_RETRY  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .rst_req    (rst_req),
    .ready      (ready),
    .fail       (fail)
`ifdef JTFRAME_PLLSEQ_DBG_EN
    ,
    .loss_cnt   (loss_cnt),
    .try_cnt    (try_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_en) begin
      tog_cnt++;
      if (tog_cnt == 6) begin
        tog_cnt = 0;
        pll_locked = ~pll_locked;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_high(output int cnt);
    cnt = 0;
    while (pll_rst && !fail && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    while (!pll_rst && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    // reset values
    repeat (2) tick();
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_rst_req", 32'(rst_req), 32'h7);
    chk("rst_ready",   32'(ready),   32'd0);
    chk("rst_fail",    32'(fail),    32'd0);

    // 1: first power-up sequence
    rst_n = 1'b1;
    count_high(n);
    chk("t1_rst_cycles", 32'(n), 32'd4);
    repeat (10) tick();
    pll_locked = 1'b1;
    repeat (10) tick();
    chk("t1_hold_111", 32'(rst_req), 32'h7);
    tick();
    chk("t1_rel0", 32'(rst_req), 32'h6);
    repeat (4) tick();
    chk("t1_gap0", 32'(rst_req), 32'h6);
    tick();
    chk("t1_rel1", 32'(rst_req), 32'h4);
    repeat (4) tick();
    chk("t1_gap1", 32'(rst_req), 32'h4);
    chk("t1_not_ready", 32'(ready), 32'd0);
    tick();
    chk("t1_rel2", 32'(rst_req), 32'h0);
    chk("t1_ready", 32'(ready), 32'd1);
    chk("t1_pll_rst", 32'(pll_rst), 32'd0);

    // 2: short glitch ignored, long drop restarts
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    chk("t2_glitch_req", 32'(rst_req), 32'h0);
    chk("t2_glitch_ready", 32'(ready), 32'd1);
    pll_locked = 1'b0;
    repeat (4) tick();
    chk("t2_drop_pending", 32'(ready), 32'd1);
    tick();
    chk("t2_drop_req", 32'(rst_req), 32'h7);
    chk("t2_drop_ready", 32'(ready), 32'd0);
    chk("t2_drop_pll_rst", 32'(pll_rst), 32'd1);

    // 3: lock never returns -> two timeouts then fail
    count_high(n);
    chk("t3_rst_a", 32'(n), 32'd4);
    count_low(n);
    chk("t3_to_a", 32'(n), 32'd100);
    chk("t3_retry_not_fail", 32'(fail), 32'd0);
    count_high(n);
    chk("t3_rst_b", 32'(n), 32'd4);
    count_low(n);
    chk("t3_to_b", 32'(n), 32'd100);
    chk("t3_fail", 32'(fail), 32'd1);
    repeat (20) tick();
    chk("t3_fail_held", 32'(fail), 32'd1);
    chk("t3_pll_rst_held", 32'(pll_rst), 32'd1);
    chk("t3_req_held", 32'(rst_req), 32'h7);
`ifdef JTFRAME_PLLSEQ_DBG_EN
    chk("t3_loss_cnt", 32'(loss_cnt), 32'd1);
    chk("t3_try_cnt", 32'(try_cnt), 32'd2);
`endif

    // restart out of fail, then 4: lock toggling every 6 cycles never qualifies
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5_fail_cleared", 32'(fail), 32'd0);
    chk("t5_fail_pll_rst", 32'(pll_rst), 32'd1);
    tog_cnt = 0;
    tog_en  = 1'b1;
    count_high(n);
    chk("t4_rst", 32'(n), 32'd4);
    count_low(n);
    chk("t4_to", 32'(n), 32'd100);
    chk("t4_reenter_rst", 32'(pll_rst), 32'd1);
    chk("t4_no_fail", 32'(fail), 32'd0);
    count_high(n);
    count_low(n);
    chk("t4_retry_kept", 32'(fail), 32'd1);
    tog_en = 1'b0;
`ifdef JTFRAME_PLLSEQ_DBG_EN
    chk("t4_try_cnt", 32'(try_cnt), 32'd4);
`endif

    // 5: restart mid-release, full sequence repeats
    restart = 1'b1;
    tick();
    restart = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    while (rst_req != 3'b100 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_reach_100", 32'(rst_req), 32'h4);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("t5_restart_req", 32'(rst_req), 32'h7);
    chk("t5_restart_pll_rst", 32'(pll_rst), 32'd1);
    chk("t5_restart_ready", 32'(ready), 32'd0);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("t5_cycles_to_ready", 32'(n), 32'd23);
    chk("t5_final_req", 32'(rst_req), 32'h0);

    // 6: asynchronous reset mid-run
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_pll_rst", 32'(pll_rst), 32'd1);
    chk("t6_req", 32'(rst_req), 32'h7);
    chk("t6_ready", 32'(ready), 32'd0);
    chk("t6_fail", 32'(fail), 32'd0);
`ifdef JTFRAME_PLLSEQ_DBG_EN
    chk("t6_loss_cnt", 32'(loss_cnt), 32'd0);
    chk("t6_try_cnt", 32'(try_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
